// File: rtl/div_inverse_pkg.sv
// Shared widths and FSM state encoding for the divider inverse checker.
// Reconstructs q*d+r with a shift-add multiplier and reports the error against n.
package div_inverse_pkg;

  localparam int Q_W       = 8;
  localparam int D_W       = 8;
  localparam int N_W       = 16;
  localparam int SUM_W     = 32;
  localparam int CNT_W     = 16;
  localparam int MUL_STEPS = 8;
  localparam int STEP_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ERR  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/abs_diff16.sv
// Combinational 16-bit unsigned absolute difference |a - b|.
module abs_diff16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  always_comb begin
    y = '0;
    if (a >= b) y = a - b;
    else        y = b - a;
  end

endmodule

// File: rtl/div_inverse_check.sv
// Checks a divider result by rebuilding n_hat = q*d + r and accumulating |n - n_hat|.
// Handshakes: a transfer happens on an edge where valid && ready; valid holds data stable until then.
module div_inverse_check
  import div_inverse_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [Q_W-1:0]      q,
  input  logic [D_W-1:0]      d,
  input  logic [Q_W-1:0]      r,
  input  logic [N_W-1:0]      n,
  input  logic                acc_clr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N_W-1:0]      n_hat,
  output logic [N_W-1:0]      err,
  output logic [SUM_W-1:0]    err_sum,
  output logic [CNT_W-1:0]    sample_cnt
);

  state_t             state;
  state_t             state_next;

  logic [Q_W-1:0]     mplier;
  logic [N_W-1:0]     mcand;
  logic [N_W-1:0]     acc;
  logic [N_W-1:0]     n_lat;
  logic [STEP_W-1:0]  step;
  logic               err_phase;
  logic [N_W-1:0]     diff;
  logic               commit;
  logic [SUM_W:0]     sum_wide;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // ERR spans two edges (settle, then commit) so out_valid lands 10 edges after accept.
  assign commit = (state == ERR) && err_phase;

  abs_diff16 u_abs_diff (
    .a (n_lat),
    .b (acc),
    .y (diff)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = MUL;
      MUL:  if (step == STEP_W'(MUL_STEPS - 1)) state_next = ERR;
      ERR:  if (err_phase) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mplier    <= '0;
      mcand     <= '0;
      acc       <= '0;
      n_lat     <= '0;
      step      <= '0;
      err_phase <= 1'b0;
      n_hat     <= '0;
      err       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mplier    <= q;
            mcand     <= {{(N_W-D_W){1'b0}}, d};
            acc       <= {{(N_W-Q_W){1'b0}}, r};
            n_lat     <= n;
            step      <= '0;
            err_phase <= 1'b0;
          end
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          step   <= step + 1'b1;
        end
        ERR: begin
          if (!err_phase) begin
            err_phase <= 1'b1;
          end else begin
            n_hat <= acc;
            err   <= diff;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum_wide = {1'b0, err_sum} + {{(SUM_W+1-N_W){1'b0}}, diff};

  // Clear wins over a coinciding commit so the in-flight sample is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sum    <= '0;
      sample_cnt <= '0;
    end else if (acc_clr) begin
      err_sum    <= '0;
      sample_cnt <= '0;
    end else if (commit) begin
      err_sum    <= sum_wide[SUM_W] ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
      if (sample_cnt != {CNT_W{1'b1}}) sample_cnt <= sample_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_div_inverse_check.sv
// Directed scoreboard bench for div_inverse_check: stimulus pushes expected results, a monitor pops on each output handshake.
module tb_div_inverse_check;

  localparam int W = 80;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  q;
  logic [7:0]  d;
  logic [7:0]  r;
  logic [15:0] n;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] n_hat;
  logic [15:0] err;
  logic [31:0] err_sum;
  logic [15:0] sample_cnt;

  logic [W-1:0] exp_q[$];
  int check_cnt = 0;
  int pass_cnt  = 0;

  div_inverse_check dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .q          (q),
    .d          (d),
    .r          (r),
    .n          (n),
    .acc_clr    (acc_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .n_hat      (n_hat),
    .err        (err),
    .err_sum    (err_sum),
    .sample_cnt (sample_cnt)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    check_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("queue_nonempty", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("n_hat",      {16'd0, n_hat},      {16'd0, e[79:64]});
        check("err",        {16'd0, err},        {16'd0, e[63:48]});
        check("err_sum",    err_sum,             e[47:16]);
        check("sample_cnt", {16'd0, sample_cnt}, {16'd0, e[15:0]});
      end
    end
  end

  // driver tasks
  task automatic wait_ready();
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 50) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic send(input logic [7:0] tq, input logic [7:0] td, input logic [7:0] tr,
                      input logic [15:0] tn, input bit push,
                      input logic [15:0] e_nhat, input logic [15:0] e_err,
                      input logic [31:0] e_sum, input logic [15:0] e_cnt);
    wait_ready();
    q = tq; d = td; r = tr; n = tn;
    in_valid = 1'b1;
    if (push) exp_q.push_back({e_nhat, e_err, e_sum, e_cnt});
    @(posedge clk); #1;
    in_valid = 1'b0;
    q = 8'($urandom_range(0, 255));
    d = 8'($urandom_range(0, 255));
    r = 8'($urandom_range(0, 255));
    n = 16'($urandom_range(0, 65535));
  endtask

  initial begin
    int lat;
    int k;
    rst_n = 1'b0; in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    q = '0; d = '0; r = '0; n = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_in_ready",   {31'd0, in_ready},   32'd1);
    check("rst_out_valid",  {31'd0, out_valid},  32'd0);
    check("rst_n_hat",      {16'd0, n_hat},      32'd0);
    check("rst_err",        {16'd0, err},        32'd0);
    check("rst_err_sum",    err_sum,             32'd0);
    check("rst_sample_cnt", {16'd0, sample_cnt}, 32'd0);

    // 18*7+3 = 129, exact; also measure latency from accept
    send(8'd18, 8'd7, 8'd3, 16'd129, 1'b1, 16'd129, 16'd0, 32'd0, 16'd1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd10);

    // 255*255+255 = 65280, err = 65535-65280 = 255
    send(8'd255, 8'd255, 8'd255, 16'hFFFF, 1'b1, 16'd65280, 16'd255, 32'd255, 16'd2);

    wait_ready();
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    check("clr_err_sum",    err_sum,             32'd0);
    check("clr_sample_cnt", {16'd0, sample_cnt}, 32'd0);

    // 20*5+1 = 101 vs 100, then d=q=0 gives r
    send(8'd20, 8'd5, 8'd1, 16'd100, 1'b1, 16'd101, 16'd1, 32'd1, 16'd1);
    send(8'd0,  8'd0, 8'd9, 16'd0,   1'b1, 16'd9,   16'd9, 32'd10, 16'd2);

    // stall in DONE: 3*4+0 = 12 vs 20 -> err 8
    wait_ready();
    out_ready = 1'b0;
    send(8'd3, 8'd4, 8'd0, 16'd20, 1'b1, 16'd12, 16'd8, 32'd18, 16'd3);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("stall_reached_done", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall_n_hat",      {16'd0, n_hat},      32'd12);
      check("stall_err",        {16'd0, err},        32'd8);
      check("stall_in_ready",   {31'd0, in_ready},   32'd0);
      check("stall_sample_cnt", {16'd0, sample_cnt}, 32'd3);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release_idle", {31'd0, in_ready}, 32'd1);

    // reset during the 4th MUL step
    send(8'd9, 8'd9, 8'd0, 16'd81, 1'b0, 16'd0, 16'd0, 32'd0, 16'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_in_ready",   {31'd0, in_ready},   32'd1);
    check("midrst_out_valid",  {31'd0, out_valid},  32'd0);
    check("midrst_err_sum",    err_sum,             32'd0);
    check("midrst_sample_cnt", {16'd0, sample_cnt}, 32'd0);

    // acc_clr on the commit edge: 10*10 = 100 vs 105 -> err 5, not counted
    send(8'd10, 8'd10, 8'd0, 16'd105, 1'b1, 16'd100, 16'd5, 32'd0, 16'd0);
    repeat (9) @(posedge clk);
    #1 acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    check("clr_commit_valid", {31'd0, out_valid}, 32'd1);

    // counting resumes: 1*1+1 = 2 vs 5 -> err 3
    send(8'd1, 8'd1, 8'd1, 16'd5, 1'b1, 16'd2, 16'd3, 32'd3, 16'd1);

    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
